// File: rtl/keypad_scanner.sv
// Purpose: scans a 4x3 active-low keypad, debounces presses and releases, emits one code per press.
// Latency: pulse at most 3*SCAN_DIV + DEBOUNCE_CYCLES + 4 cycles after a row goes low.
// Backpressure: none; pulses are fire-and-forget and a held key never repeats.
module keypad_scanner #(
    parameter int SCAN_DIV        = 256,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    output logic [3:0] key,
    output logic       shift,
    output logic       cmd_star,
    output logic       cmd_hash,
    output logic       key_held
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_EMIT,
        S_WAIT_RELEASE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_sync1, r_rs;
    logic [1:0]       r_col, w_col_nxt, w_col_inc;
    logic [DIV_W-1:0] r_div_cnt, w_div_cnt_nxt;
    logic [DB_W-1:0]  r_db_cnt, w_db_cnt_nxt;
    logic [3:0]       r_cap, w_cap_nxt;
    logic [3:0]       r_key, w_key_nxt;
    logic             r_shift, w_shift_nxt;
    logic             r_star, w_star_nxt;
    logic             r_hash, w_hash_nxt;
    logic             r_held, w_held_nxt;
    logic [3:0]       w_low;
    logic             w_one_low;
    logic [1:0]       w_row;
    logic [3:0]       w_code;

    // Two-flop synchronizer; idle rows read as all-high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 4'hF;
            r_rs    <= 4'hF;
        end else begin
            r_sync1 <= row_in;
            r_rs    <= r_sync1;
        end
    end

    // A valid press pulls exactly one row low; more than one is a ghost or multi-press.
    assign w_low     = ~r_rs;
    assign w_one_low = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
    assign w_col_inc = (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;

    // Decode the captured row pattern and held column into the key code.
    always_comb begin
        w_row  = 2'd0;
        w_code = 4'h0;
        case (r_cap)
            4'b1110: w_row = 2'd0;
            4'b1101: w_row = 2'd1;
            4'b1011: w_row = 2'd2;
            4'b0111: w_row = 2'd3;
            default: w_row = 2'd0;
        endcase
        case ({w_row, r_col})
            4'b00_00: w_code = 4'h1;
            4'b00_01: w_code = 4'h2;
            4'b00_10: w_code = 4'h3;
            4'b01_00: w_code = 4'h4;
            4'b01_01: w_code = 4'h5;
            4'b01_10: w_code = 4'h6;
            4'b10_00: w_code = 4'h7;
            4'b10_01: w_code = 4'h8;
            4'b10_10: w_code = 4'h9;
            4'b11_00: w_code = 4'hA;
            4'b11_01: w_code = 4'h0;
            4'b11_10: w_code = 4'hB;
            default:  w_code = 4'h0;
        endcase
    end

    // Drive exactly one column low; the unused index falls back to column 0.
    always_comb begin
        case (r_col)
            2'd1:    col_out = 3'b101;
            2'd2:    col_out = 3'b011;
            default: col_out = 3'b110;
        endcase
    end

    // Next-state and next-output logic for scan, debounce, emit and release tracking.
    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_div_cnt_nxt = r_div_cnt;
        w_db_cnt_nxt  = r_db_cnt;
        w_cap_nxt     = r_cap;
        w_key_nxt     = r_key;
        w_shift_nxt   = 1'b0;
        w_star_nxt    = 1'b0;
        w_hash_nxt    = 1'b0;
        w_held_nxt    = r_held;
        case (r_state)
            S_SCAN: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_cnt_nxt = '0;
                    if (w_one_low) begin
                        // Column stays put so the debounce watches the same key.
                        w_cap_nxt    = r_rs;
                        w_db_cnt_nxt = '0;
                        w_state_nxt  = S_DEBOUNCE;
                    end else begin
                        w_col_nxt = w_col_inc;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
                end
            end
            S_DEBOUNCE: begin
                if (r_rs == r_cap) begin
                    if (r_db_cnt == DB_LAST) begin
                        w_db_cnt_nxt = '0;
                        w_state_nxt  = S_EMIT;
                    end else begin
                        w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                    end
                end else begin
                    w_db_cnt_nxt = '0;
                    w_col_nxt    = w_col_inc;
                    w_state_nxt  = S_SCAN;
                end
            end
            S_EMIT: begin
                w_key_nxt    = w_code;
                w_shift_nxt  = (w_code < 4'hA);
                w_star_nxt   = (w_code == 4'hA);
                w_hash_nxt   = (w_code == 4'hB);
                w_held_nxt   = 1'b1;
                w_db_cnt_nxt = '0;
                w_state_nxt  = S_WAIT_RELEASE;
            end
            S_WAIT_RELEASE: begin
                if (r_rs == 4'hF) begin
                    if (r_db_cnt == DB_LAST) begin
                        w_db_cnt_nxt = '0;
                        w_held_nxt   = 1'b0;
                        w_col_nxt    = w_col_inc;
                        w_state_nxt  = S_SCAN;
                    end else begin
                        w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                    end
                end else begin
                    w_db_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = S_SCAN;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_SCAN;
            r_col     <= 2'd0;
            r_div_cnt <= '0;
            r_db_cnt  <= '0;
            r_cap     <= 4'hF;
            r_key     <= 4'h0;
            r_shift   <= 1'b0;
            r_star    <= 1'b0;
            r_hash    <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_db_cnt  <= w_db_cnt_nxt;
            r_cap     <= w_cap_nxt;
            r_key     <= w_key_nxt;
            r_shift   <= w_shift_nxt;
            r_star    <= w_star_nxt;
            r_hash    <= w_hash_nxt;
            r_held    <= w_held_nxt;
        end
    end

    assign key      = r_key;
    assign shift    = r_shift;
    assign cmd_star = r_star;
    assign cmd_hash = r_hash;
    assign key_held = r_held;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4-row x 3-column active-low keypad matrix, debounces presses and emits one decoded key code per press.
- Generates the `key`/`shift` stream that loads the alarm clock's 4-digit key buffer, plus command pulses for the two non-digit keys.
- Sits between the keypad pins and the key buffer / clock control FSM.

Parameters:
- SCAN_DIV, 256, clock cycles each column is driven before advancing; must be >= 4.
- DEBOUNCE_CYCLES, 1024, consecutive stable cycles needed to accept a press or a release; must be >= 2.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- row_in  input  4  keypad rows, active-low with external pull-ups, asynchronous to clock
- col_out  output  3  column drive, active-low, exactly one bit low at any time
- key  output  4  last accepted key code
- shift  output  1  one-cycle pulse on acceptance of a digit key
- cmd_star  output  1  one-cycle pulse on acceptance of '*'
- cmd_hash  output  1  one-cycle pulse on acceptance of '#'
- key_held  output  1  high while an accepted key is still pressed or its release is being debounced

Behaviour:
- Input sync: `row_in` passes through a 2-flop synchronizer that resets to 4'hF. All decisions use the synchronized value (`rs`).
- Key map, as (row, col) -> code:
  - r0: 1, 2, 3
  - r1: 4, 5, 6
  - r2: 7, 8, 9
  - r3: '*'=4'hA, 0=4'h0, '#'=4'hB
- Reset values: state SCAN, column index 0, `col_out`=3'b110, `key`=0, `shift`/`cmd_star`/`cmd_hash`/`key_held`=0, all counters 0.
- SCAN:
  - Drive the current column low for SCAN_DIV cycles, then advance the index 0->1->2->0.
  - Sample `rs` only on the last dwell cycle so the synchronizer has settled.
  - Exactly one row low: capture row and column, clear the debounce counter, go to DEBOUNCE. The column does not advance.
  - All rows high, or two or more rows low (ghost/multi-press): ignore and advance normally.
- DEBOUNCE:
  - Hold the column. Increment the counter each cycle `rs` equals the captured pattern.
  - Any mismatch: return to SCAN, advance to the next column, clear the counter.
  - Counter reaches DEBOUNCE_CYCLES-1 on a matching cycle: go to EMIT.
- EMIT (exactly one cycle):
  - Register `key` = mapped code.
  - Next cycle, assert exactly one of `shift` (codes 0-9), `cmd_star` (A) or `cmd_hash` (B).
  - `key` is stable from the pulse cycle onward and holds until the next EMIT.
  - Go to WAIT_RELEASE and set `key_held`=1 together with the pulse.
- WAIT_RELEASE:
  - Hold the column. Count consecutive cycles with `rs`==4'hF; any low row clears the count.
  - Count reaches DEBOUNCE_CYCLES-1: clear `key_held`, advance the column, go to SCAN.
  - A held key never produces a second pulse (no auto-repeat).
  - A second key pressed while the first is held is ignored until full release.
- Pulses: `shift`, `cmd_star` and `cmd_hash` are mutually exclusive and never high for two consecutive cycles.
- Counters: sized $clog2 of each parameter, saturate-free. Every transition clears its counter.
- Reset mid-operation: returns to reset values immediately; no pulse is emitted for the interrupted press. A key still held after reset is re-detected by a fresh scan and emitted once.
- Press-to-pulse latency: at most 3*SCAN_DIV + DEBOUNCE_CYCLES + 4 cycles after row_in goes low.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8 unless stated):
- Reset, no keys -> `col_out` cycles 110, 101, 011 every 4 cycles. `key`=0, no pulses, `key_held`=0.
- Press '7' (row2 low while col0 low) held 60 cycles, then release -> exactly one `shift`, `key`=4'h7. `key_held` high from the pulse until 8 clean high cycles after release.
- Press '5' bouncing low/high every 3 cycles for 30 cycles, then released -> no `shift`, `key` unchanged, scan continues.
- Press '*', then '#' -> `key`=4'hA with one `cmd_star` and no `shift`; then `key`=4'hB with one `cmd_hash`.
- Rows 0 and 1 low together on col1 -> no pulse, `key_held` stays 0. Sequence 1, 2, 0, 5 with full releases -> four `shift` pulses carrying `key` 1, 2, 0, 5 in order.
- Assert `reset` during WAIT_RELEASE with '3' held -> outputs return to reset values at once. After deassert, one new `shift` with `key`=3, and no pulse during reset.
